ss_adc_capture_ctrl: RTL and testbench

Conversion controller for the single-slope pixel ADC. It generates the digital ramp code for the ramp DAC and consumes the per-pixel one-cycle rising-edge pulses from the comparator edge detector. On each pixel's first pulse it latches the current ramp code, then streams the captured codes out over a valid/ready interface. It sits between the edge detector (upstream) and the readout/serializer logic (downstream).

---
 rtl/ss_adc_pkg.sv | 20 ++
 rtl/ss_adc_pixel_latch.sv | 44 ++++
 rtl/ss_adc_capture_ctrl.sv | 140 ++++++++++++++
 tb/tb_ss_adc_capture_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ss_adc_pkg.sv
// Shared state encoding and ramp saturation helper for the single-slope ADC capture controller.
package ss_adc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RAMP    = 2'd1,
    READOUT = 2'd2
  } adc_state_t;

  // All-ones code of the given width: last ramp step and the "no edge seen" report value.
  function automatic logic [31:0] sat_code(input int unsigned width);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < width) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/ss_adc_pixel_latch.sv
// Per-pixel first-edge capture register with end-of-ramp saturation.
// Optional SS_ADC_OVF_FLAG_EN exposes the captured flag to the controller.
module ss_adc_pixel_latch
  import ss_adc_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             capture,
  input  logic             saturate,
  input  logic [CNT_W-1:0] ramp_code,
  output logic [CNT_W-1:0] code
`ifdef SS_ADC_OVF_FLAG_EN
  ,
  output logic             captured
`endif
);

  localparam logic [CNT_W-1:0] SAT_CODE = CNT_W'(sat_code(CNT_W));

  logic captured_q;

  // A capture on the final ramp step outranks saturation so the flag stays truthful.
  always_ff @(posedge clk) begin
    if (reset) begin
      captured_q <= 1'b0;
      code       <= '0;
    end else if (clear) begin
      captured_q <= 1'b0;
    end else if (capture && !captured_q) begin
      captured_q <= 1'b1;
      code       <= ramp_code;
    end else if (saturate && !captured_q) begin
      code       <= SAT_CODE;
    end
  end

`ifdef SS_ADC_OVF_FLAG_EN
  assign captured = captured_q;
`endif

endmodule

// File: rtl/ss_adc_capture_ctrl.sv
// Single-slope ADC conversion controller: ramp generation, first-edge capture, valid/ready readout.
// Optional SS_ADC_OVF_FLAG_EN adds out_ovf marking pixels that never saw an edge.
//
// state   | meaning
// IDLE    | waiting for start; ramp_code held at 0
// RAMP    | ramp_code counts 0..2^CNT_W-1, pixels capture their first edge
// READOUT | captured codes streamed out in pixel order
module ss_adc_capture_ctrl
  import ss_adc_pkg::*;
#(
  parameter int NUM_PIXELS = 1,
  parameter int CNT_W      = 8,
  parameter int IDX_W      = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [NUM_PIXELS-1:0] enable,
  output logic [CNT_W-1:0]      ramp_code,
  output logic                  ramp_active,
  output logic                  busy,
  output logic [CNT_W-1:0]      out_data,
  output logic [IDX_W-1:0]      out_idx,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  done
`ifdef SS_ADC_OVF_FLAG_EN
  ,
  output logic                  out_ovf
`endif
);

  localparam logic [CNT_W-1:0] RAMP_LAST = CNT_W'(sat_code(CNT_W));
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_PIXELS - 1);

  adc_state_t       state, state_nx;
  logic             clear_flags, capture_en, ramp_end, xfer, last_xfer;
  logic [CNT_W-1:0] codes [NUM_PIXELS];

  // A start coinciding with the done pulse is dropped; restart is possible one cycle later.
  always_comb begin
    state_nx    = state;
    clear_flags = 1'b0;
    capture_en  = 1'b0;
    ramp_end    = 1'b0;
    xfer        = 1'b0;
    last_xfer   = 1'b0;
    case (state)
      IDLE: begin
        if (start && !done) begin
          state_nx    = RAMP;
          clear_flags = 1'b1;
        end
      end
      RAMP: begin
        capture_en = 1'b1;
        if (ramp_code == RAMP_LAST) begin
          ramp_end = 1'b1;
          state_nx = READOUT;
        end
      end
      READOUT: begin
        xfer = out_valid && out_ready;
        if (xfer && (out_idx == LAST_IDX)) begin
          last_xfer = 1'b1;
          state_nx  = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ramp_code <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      done      <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= last_xfer;
      if (clear_flags || ramp_end) begin
        ramp_code <= '0;
      end else if (capture_en) begin
        ramp_code <= ramp_code + CNT_W'(1);
      end
      if (ramp_end) begin
        out_valid <= 1'b1;
        out_idx   <= '0;
      end else if (last_xfer) begin
        out_valid <= 1'b0;
        out_idx   <= '0;
      end else if (xfer) begin
        out_idx   <= out_idx + IDX_W'(1);
      end
    end
  end

  assign ramp_active = (state == RAMP);
  assign busy        = (state != IDLE);

`ifdef SS_ADC_OVF_FLAG_EN
  logic [NUM_PIXELS-1:0] captured;
`endif

  for (genvar i = 0; i < NUM_PIXELS; i++) begin : g_pix
    ss_adc_pixel_latch #(.CNT_W(CNT_W)) u_latch (
      .clk       (clk),
      .reset     (reset),
      .clear     (clear_flags),
      .capture   (capture_en && enable[i]),
      .saturate  (ramp_end),
      .ramp_code (ramp_code),
      .code      (codes[i])
`ifdef SS_ADC_OVF_FLAG_EN
      ,
      .captured  (captured[i])
`endif
    );
  end

  always_comb begin
    out_data = '0;
    for (int i = 0; i < NUM_PIXELS; i++) begin
      if (out_idx == IDX_W'(i)) out_data = codes[i];
    end
  end

`ifdef SS_ADC_OVF_FLAG_EN
  // Gated by out_valid so the flag reads 0 out of reset and between conversions.
  always_comb begin
    out_ovf = 1'b0;
    for (int i = 0; i < NUM_PIXELS; i++) begin
      if (out_idx == IDX_W'(i)) out_ovf = out_valid && !captured[i];
    end
  end
`endif

endmodule

// File: tb/tb_ss_adc_capture_ctrl.sv
// Directed self-checking bench for ss_adc_capture_ctrl (CNT_W=4, NUM_PIXELS=2).
// Checks out_ovf as well when SS_ADC_OVF_FLAG_EN is defined.
module tb_ss_adc_capture_ctrl;

  localparam int CNT_W      = 4;
  localparam int NUM_PIXELS = 2;
  localparam int IDX_W      = 1;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  start;
  logic [NUM_PIXELS-1:0] enable;
  logic [CNT_W-1:0]      ramp_code;
  logic                  ramp_active;
  logic                  busy;
  logic [CNT_W-1:0]      out_data;
  logic [IDX_W-1:0]      out_idx;
  logic                  out_valid;
  logic                  out_ready;
  logic                  done;
`ifdef SS_ADC_OVF_FLAG_EN
  logic                  out_ovf;
`endif

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ss_adc_capture_ctrl #(
    .NUM_PIXELS (NUM_PIXELS),
    .CNT_W      (CNT_W),
    .IDX_W      (IDX_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .enable      (enable),
    .ramp_code   (ramp_code),
    .ramp_active (ramp_active),
    .busy        (busy),
    .out_data    (out_data),
    .out_idx     (out_idx),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .done        (done)
`ifdef SS_ADC_OVF_FLAG_EN
    ,
    .out_ovf     (out_ovf)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic begin_conv;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Walks the 16 ramp cycles, pulsing pixel i wherever its mask bit for the current code is set.
  task automatic run_ramp(input logic [15:0] m0, input logic [15:0] m1, input int start_at);
    for (int k = 0; k < 16; k++) begin
      vectors++;
      if ({ramp_code, ramp_active, busy, out_valid, done} !== {4'(k), 4'b1100}) begin
        miscompares++;
        $display("FAIL ramp_step k=%0d: got code=%0d act=%b busy=%b valid=%b done=%b, want code=%0d act=1 busy=1 valid=0 done=0",
                 k, ramp_code, ramp_active, busy, out_valid, done, k);
      end
      enable = {m1[k], m0[k]};
      start  = (k == start_at);
      tick();
    end
    enable = '0;
    start  = 1'b0;
  endtask

  // Drains READOUT using ready pattern rdy_pat (bit c = out_ready in readout cycle c), then checks done.
  task automatic readout(input logic [3:0] e0, input logic [3:0] e1, input logic o0, input logic o1,
                         input logic [31:0] rdy_pat, input logic [1:0] en_val, input int start_at,
                         input bit start_on_done, output int cycles);
    int         nxt;
    int         c;
    bit         got;
    logic [3:0] exp_code;
    logic       exp_ovf;
    logic       rdy;
    nxt = 0;
    c   = 0;
    got = 1'b0;
    while (!got && c < 64) begin
      if (nxt == NUM_PIXELS) begin
        vectors++;
        if ({done, out_valid, busy} !== 3'b100) begin
          miscompares++;
          $display("FAIL done_pulse: got done=%b valid=%b busy=%b, want done=1 valid=0 busy=0",
                   done, out_valid, busy);
        end
        got = 1'b1;
      end else begin
        exp_code = (nxt == 0) ? e0 : e1;
        exp_ovf  = (nxt == 0) ? o0 : o1;
        vectors++;
        if ({done, out_valid, busy, out_idx, out_data} !== {3'b011, 1'(nxt), exp_code}) begin
          miscompares++;
          $display("FAIL readout c=%0d: got done=%b valid=%b busy=%b idx=%0d data=%0d, want done=0 valid=1 busy=1 idx=%0d data=%0d (no-edge=%b)",
                   c, done, out_valid, busy, out_idx, out_data, nxt, exp_code, exp_ovf);
        end
`ifdef SS_ADC_OVF_FLAG_EN
        vectors++;
        if (out_ovf !== exp_ovf) begin
          miscompares++;
          $display("FAIL out_ovf c=%0d idx=%0d: got %b, want %b", c, nxt, out_ovf, exp_ovf);
        end
`endif
        rdy       = (c < 32) ? rdy_pat[c] : 1'b1;
        out_ready = rdy;
        enable    = en_val;
        start     = (c == start_at);
        tick();
        if (rdy) nxt++;
        c++;
      end
    end
    out_ready = 1'b0;
    enable    = '0;
    start     = 1'b0;
    if (!got) begin
      vectors++;
      miscompares++;
      $display("FAIL readout_timeout: got %0d of %0d pixels after %0d cycles, want done", nxt, NUM_PIXELS, c);
    end
    start = start_on_done;
    tick();
    start = 1'b0;
    vectors++;
    if ({done, busy} !== 2'b00) begin
      miscompares++;
      $display("FAIL after_done: got done=%b busy=%b, want done=0 busy=0", done, busy);
    end
    cycles = c;
  endtask

  task automatic test_reset;
    reset     = 1'b1;
    start     = 1'b0;
    enable    = '0;
    out_ready = 1'b0;
    tick();
    tick();
    vectors++;
    if ({ramp_code, ramp_active, busy, out_valid, out_idx, out_data, done} !== 13'd0) begin
      miscompares++;
      $display("FAIL reset_values: got code=%0d act=%b busy=%b valid=%b idx=%0d data=%0d done=%b, want all 0",
               ramp_code, ramp_active, busy, out_valid, out_idx, out_data, done);
    end
`ifdef SS_ADC_OVF_FLAG_EN
    vectors++;
    if (out_ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ovf: got %b, want 0", out_ovf);
    end
`endif
    reset = 1'b0;
  endtask

  task automatic test_basic;
    int cyc;
    begin_conv();
    run_ramp(16'h0020, 16'h0800, -1);
    readout(4'd5, 4'd11, 1'b0, 1'b0, 32'hFFFF_FFFF, 2'b00, -1, 1'b0, cyc);
    vectors++;
    if (cyc !== 2) begin
      miscompares++;
      $display("FAIL basic_readout_len: got %0d cycles, want 2", cyc);
    end
  endtask

  task automatic test_first_edge_and_saturate;
    int cyc;
    begin_conv();
    run_ramp(16'h0208, 16'h0000, -1);
    readout(4'd3, 4'd15, 1'b0, 1'b1, 32'hFFFF_FFFF, 2'b00, -1, 1'b0, cyc);
  endtask

  task automatic test_simultaneous_and_ignored;
    int cyc;
    enable = 2'b11;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if ({busy, ramp_code} !== 5'd0) begin
        miscompares++;
        $display("FAIL idle_pulse i=%0d: got busy=%b code=%0d, want busy=0 code=0", i, busy, ramp_code);
      end
    end
    enable = '0;
    begin_conv();
    run_ramp(16'h0001, 16'h0001, -1);
    readout(4'd0, 4'd0, 1'b0, 1'b0, 32'h0000_000C, 2'b11, -1, 1'b0, cyc);
  endtask

  task automatic test_backpressure;
    int cyc;
    begin_conv();
    run_ramp(16'h0100, 16'h0004, -1);
    readout(4'd8, 4'd2, 1'b0, 1'b0, 32'h0000_0050, 2'b00, -1, 1'b0, cyc);
    vectors++;
    if (cyc !== 7) begin
      miscompares++;
      $display("FAIL backpressure_len: got %0d cycles, want 7", cyc);
    end
  endtask

  task automatic test_start_while_busy;
    int cyc;
    begin_conv();
    run_ramp(16'h0400, 16'h0080, 8);
    readout(4'd10, 4'd7, 1'b0, 1'b0, 32'hFFFF_FFFF, 2'b00, 0, 1'b1, cyc);
    begin_conv();
    run_ramp(16'h0004, 16'h4000, -1);
    readout(4'd2, 4'd14, 1'b0, 1'b0, 32'hFFFF_FFFF, 2'b00, -1, 1'b0, cyc);
  endtask

  task automatic test_abort;
    int cyc;
    begin_conv();
    for (int k = 0; k < 7; k++) begin
      enable = {1'b0, (k == 3)};
      tick();
    end
    enable = '0;
    vectors++;
    if ({ramp_code, ramp_active} !== {4'd7, 1'b1}) begin
      miscompares++;
      $display("FAIL abort_ramp_pos: got code=%0d act=%b, want code=7 act=1", ramp_code, ramp_active);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++;
    if ({ramp_code, ramp_active, busy, out_valid, out_idx, out_data, done} !== 13'd0) begin
      miscompares++;
      $display("FAIL abort_ramp_reset: got code=%0d act=%b busy=%b valid=%b idx=%0d data=%0d done=%b, want all 0",
               ramp_code, ramp_active, busy, out_valid, out_idx, out_data, done);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if ({done, busy} !== 2'b00) begin
        miscompares++;
        $display("FAIL abort_ramp_quiet i=%0d: got done=%b busy=%b, want 0 0", i, done, busy);
      end
    end

    begin_conv();
    run_ramp(16'h0040, 16'h0200, -1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    vectors++;
    if ({out_valid, out_idx, out_data} !== {1'b1, 1'b1, 4'd9}) begin
      miscompares++;
      $display("FAIL abort_readout_pos: got valid=%b idx=%0d data=%0d, want valid=1 idx=1 data=9",
               out_valid, out_idx, out_data);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++;
    if ({ramp_code, ramp_active, busy, out_valid, out_idx, out_data, done} !== 13'd0) begin
      miscompares++;
      $display("FAIL abort_readout_reset: got code=%0d act=%b busy=%b valid=%b idx=%0d data=%0d done=%b, want all 0",
               ramp_code, ramp_active, busy, out_valid, out_idx, out_data, done);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if ({done, busy} !== 2'b00) begin
        miscompares++;
        $display("FAIL abort_readout_quiet i=%0d: got done=%b busy=%b, want 0 0", i, done, busy);
      end
    end

    begin_conv();
    run_ramp(16'h0002, 16'h8000, -1);
    readout(4'd1, 4'd15, 1'b0, 1'b0, 32'hFFFF_FFFF, 2'b00, -1, 1'b0, cyc);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_first_edge_and_saturate();
    test_simultaneous_and_ignored();
    test_backpressure();
    test_start_while_busy();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
